// File: rtl/text_console_ctrl.sv
// Command-level front end for the text-mode video card: putchar/cursor/clear in, single cell writes out.
// Optional blinking cursor overlay is enabled by defining CURSOR_EN.
module text_console_ctrl #(
    parameter int unsigned COLS      = 80,
    parameter int unsigned ROWS      = 60,
    parameter logic [15:0] FILL      = 16'h0020,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        STB,
    input  logic        WE,
    input  logic [1:0]  ADDR,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK,
    output logic        V_STB,
    output logic [31:0] V_ADDR,
    output logic [31:0] V_DAT,
    input  logic        V_ACK,
    output logic [5:0]  row_offset,
    output logic        cursor_vis,
    output logic [12:0] cursor_addr
);

    typedef enum logic [2:0] {
        IDLE,
        PUT_WR,
        ADVANCE,
        SCROLL_CLR,
        CLEAR,
        DONE
    } state_t;

    localparam logic [6:0]  COL_MAX    = 7'(COLS - 1);
    localparam logic [5:0]  ROW_MAX    = 6'(ROWS - 1);
    localparam logic [6:0]  ROWS7      = 7'(ROWS);
    localparam logic [12:0] COLS13     = 13'(COLS);
    localparam logic [12:0] ROW_LAST   = 13'(COLS - 1);
    localparam logic [12:0] CELLS_LAST = 13'(COLS * ROWS - 1);

    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic [5:0]  row_offset_q, row_offset_d;
    logic        v_stb_q, v_stb_d;
    logic [12:0] v_addr_q, v_addr_d;
    logic [15:0] v_dat_q, v_dat_d;
    logic [12:0] cnt_q, cnt_d;
    logic [12:0] base_q, base_d;
    logic        adv_q, adv_d;
    logic        line_feed;
    logic        busy;
    logic [6:0]  col_m1;
    logic [6:0]  set_col;
    logic [5:0]  set_row;

    // Logical (row, col) to physical cell index, folding the scroll offset modulo ROWS.
    function automatic logic [12:0] phys_addr(input logic [5:0] r, input logic [5:0] off,
                                              input logic [6:0] c);
        logic [6:0]  sum;
        logic [12:0] prow;
        sum = {1'b0, r} + {1'b0, off};
        if (sum >= ROWS7) begin
            sum = sum - ROWS7;
        end
        prow = {6'b0, sum};
        return 13'(prow * COLS13) + {6'b0, c};
    endfunction

    assign busy    = (state_q != IDLE);
    assign ACK     = (state_q == DONE);
    assign DAT_O   = {18'b0, busy, row_q, col_q};
    assign V_STB   = v_stb_q;
    assign V_ADDR  = {19'b0, v_addr_q};
    assign V_DAT   = {16'b0, v_dat_q};
    assign row_offset  = row_offset_q;
    assign cursor_addr = phys_addr(row_q, row_offset_q, col_q);

    assign col_m1  = col_q - 7'd1;
    assign set_col = (DAT_I[6:0] > COL_MAX) ? COL_MAX : DAT_I[6:0];
    assign set_row = (DAT_I[13:8] > ROW_MAX) ? ROW_MAX : DAT_I[13:8];

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        row_offset_d = row_offset_q;
        v_stb_d      = v_stb_q;
        v_addr_d     = v_addr_q;
        v_dat_d      = v_dat_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        adv_d        = adv_q;
        line_feed    = 1'b0;

        case (state_q)
            IDLE: begin
                if (STB && !ACK) begin
                    if (!WE) begin
                        state_d = DONE;
                    end else begin
                        case (ADDR)
                            2'd0: begin
                                case (DAT_I[7:0])
                                    8'h0A: begin
                                        col_d     = 7'd0;
                                        line_feed = 1'b1;
                                    end
                                    8'h0D: begin
                                        col_d   = 7'd0;
                                        state_d = DONE;
                                    end
                                    8'h08: begin
                                        if (col_q != 7'd0) begin
                                            col_d    = col_m1;
                                            v_stb_d  = 1'b1;
                                            v_addr_d = phys_addr(row_q, row_offset_q, col_m1);
                                            v_dat_d  = FILL;
                                            adv_d    = 1'b0;
                                            state_d  = PUT_WR;
                                        end else begin
                                            state_d = DONE;
                                        end
                                    end
                                    default: begin
                                        v_stb_d  = 1'b1;
                                        v_addr_d = phys_addr(row_q, row_offset_q, col_q);
                                        v_dat_d  = DAT_I[15:0];
                                        adv_d    = 1'b1;
                                        state_d  = PUT_WR;
                                    end
                                endcase
                            end
                            2'd1: begin
                                col_d   = set_col;
                                row_d   = set_row;
                                state_d = DONE;
                            end
                            2'd2: begin
                                cnt_d   = 13'd0;
                                state_d = CLEAR;
                            end
                            default: state_d = DONE;
                        endcase
                    end
                end
            end
            PUT_WR: begin
                if (V_ACK) begin
                    v_stb_d = 1'b0;
                    state_d = adv_q ? ADVANCE : DONE;
                end
            end
            ADVANCE: begin
                if (col_q == COL_MAX) begin
                    col_d     = 7'd0;
                    line_feed = 1'b1;
                end else begin
                    col_d   = col_q + 7'd1;
                    state_d = DONE;
                end
            end
            SCROLL_CLR, CLEAR: begin
                // Strobe drops for one cycle after every acknowledge before the next cell goes out.
                if (!v_stb_q) begin
                    v_stb_d  = 1'b1;
                    v_addr_d = (state_q == CLEAR) ? cnt_q : base_q + cnt_q;
                    v_dat_d  = FILL;
                end else if (V_ACK) begin
                    v_stb_d = 1'b0;
                    cnt_d   = cnt_q + 13'd1;
                    if (state_q == CLEAR && cnt_q == CELLS_LAST) begin
                        row_offset_d = 6'd0;
                        col_d        = 7'd0;
                        row_d        = 6'd0;
                        state_d      = DONE;
                    end else if (state_q == SCROLL_CLR && cnt_q == ROW_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // At the bottom row the screen scrolls: the old top physical row becomes the blank bottom row.
        if (line_feed) begin
            if (row_q == ROW_MAX) begin
                row_offset_d = (row_offset_q == ROW_MAX) ? 6'd0 : row_offset_q + 6'd1;
                base_d       = 13'({7'b0, row_offset_q} * COLS13);
                cnt_d        = 13'd0;
                state_d      = SCROLL_CLR;
            end else begin
                row_d   = row_q + 6'd1;
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            col_q        <= 7'd0;
            row_q        <= 6'd0;
            row_offset_q <= 6'd0;
            v_stb_q      <= 1'b0;
            v_addr_q     <= 13'd0;
            v_dat_q      <= 16'd0;
            cnt_q        <= 13'd0;
            base_q       <= 13'd0;
            adv_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            row_offset_q <= row_offset_d;
            v_stb_q      <= v_stb_d;
            v_addr_q     <= v_addr_d;
            v_dat_q      <= v_dat_d;
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            adv_q        <= adv_d;
        end
    end

    logic unused_dat_hi;
    assign unused_dat_hi = ^DAT_I[31:16];

`ifdef CURSOR_EN
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        phase_q, phase_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + 32'd1;
        phase_d     = phase_q;
        if (blink_cnt_q == 32'(BLINK_DIV - 1)) begin
            blink_cnt_d = 32'd0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= 32'd0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign cursor_vis = phase_q & ~busy;
`else
    logic unused_blink;
    assign unused_blink = (BLINK_DIV != 0);
    assign cursor_vis   = 1'b0;
`endif

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed self-checking bench for text_console_ctrl with a behavioural video-card responder.
`timescale 1ns/1ps
module tb_text_console_ctrl;

    logic        clk;
    logic        reset;
    logic        STB;
    logic        WE;
    logic [1:0]  ADDR;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK;
    logic        V_STB;
    logic [31:0] V_ADDR;
    logic [31:0] V_DAT;
    logic        v_ack;
    logic [5:0]  row_offset;
    logic        cursor_vis;
    logic [12:0] cursor_addr;

    int checks;
    int failures;

    int          ack_delay;
    int          wait_cnt;
    int          cyc;
    int          ack_cnt;
    int          last_ack_cyc;
    int          last_vack_cyc;
    int          proto_err;
    logic        hold;
    logic [31:0] hold_addr;
    logic [31:0] hold_dat;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_dat[$];

    text_console_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .STB         (STB),
        .WE          (WE),
        .ADDR        (ADDR),
        .DAT_I       (DAT_I),
        .DAT_O       (DAT_O),
        .ACK         (ACK),
        .V_STB       (V_STB),
        .V_ADDR      (V_ADDR),
        .V_DAT       (V_DAT),
        .V_ACK       (v_ack),
        .row_offset  (row_offset),
        .cursor_vis  (cursor_vis),
        .cursor_addr (cursor_addr)
    );

    always #5 clk = ~clk;

    // Video card: acks after ack_delay cycles of strobe, logs each accepted write, watches bus rules.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (ACK) begin
            ack_cnt      = ack_cnt + 1;
            last_ack_cyc = cyc;
        end
        if (reset) begin
            v_ack    = 1'b0;
            wait_cnt = 0;
            hold     = 1'b0;
        end else if (v_ack) begin
            if (V_STB) proto_err = proto_err + 1;
            v_ack    = 1'b0;
            wait_cnt = 0;
            hold     = 1'b0;
        end else if (V_STB) begin
            if (hold && (V_ADDR !== hold_addr || V_DAT !== hold_dat)) proto_err = proto_err + 1;
            hold      = 1'b1;
            hold_addr = V_ADDR;
            hold_dat  = V_DAT;
            if (wait_cnt >= ack_delay) begin
                v_ack = 1'b1;
                wr_addr.push_back(V_ADDR);
                wr_dat.push_back(V_DAT);
                last_vack_cyc = cyc;
            end else begin
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            if (hold) proto_err = proto_err + 1;
            wait_cnt = 0;
            hold     = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One CPU bus transaction; lat counts cycles from strobe to ACK, rd is DAT_O seen with ACK.
    task automatic cpu_cmd(input logic [1:0] a, input logic we_i, input logic [31:0] d,
                           input int budget, output int lat, output logic ok,
                           output logic [31:0] rd);
        STB   = 1'b1;
        ADDR  = a;
        WE    = we_i;
        DAT_I = d;
        ok    = 1'b0;
        lat   = 0;
        rd    = 32'd0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (ACK) begin
                lat = i;
                ok  = 1'b1;
                rd  = DAT_O;
                break;
            end
        end
        STB = 1'b0;
        tick(3);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks = checks + 1;
        if (ACK !== 1'b0 || V_STB !== 1'b0) begin
            failures = failures + 1;
            $display("[TB] FAIL reset_handshake ACK=%b V_STB=%b required 0/0", ACK, V_STB);
        end
        checks = checks + 1;
        if (V_ADDR !== 32'd0 || V_DAT !== 32'd0) begin
            failures = failures + 1;
            $display("[TB] FAIL reset_vbus V_ADDR=%h V_DAT=%h required 0/0", V_ADDR, V_DAT);
        end
        checks = checks + 1;
        if (row_offset !== 6'd0 || DAT_O !== 32'd0) begin
            failures = failures + 1;
            $display("[TB] FAIL reset_state row_offset=%0d DAT_O=%h required 0/0", row_offset, DAT_O);
        end
        checks = checks + 1;
        if (cursor_vis !== 1'b0 || cursor_addr !== 13'd0) begin
            failures = failures + 1;
            $display("[TB] FAIL reset_cursor vis=%b addr=%0d required 0/0", cursor_vis, cursor_addr);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_putchar();
        int lat; logic ok; logic [31:0] rd; int a0;
        ack_delay = 1;
        wr_addr.delete(); wr_dat.delete();
        a0 = ack_cnt;
        cpu_cmd(2'd0, 1'b1, 32'h0000_0741, 100, lat, ok, rd);
        checks = checks + 1;
        if (!ok || wr_addr.size() != 1) begin
            failures = failures + 1;
            $display("[TB] FAIL putchar_writes ok=%b writes=%0d required 1/1", ok, wr_addr.size());
        end else begin
            checks = checks + 1;
            if (wr_addr[0] !== 32'd0 || wr_dat[0] !== 32'h0000_0741) begin
                failures = failures + 1;
                $display("[TB] FAIL putchar_cell addr=%0d dat=%h required 0/00000741", wr_addr[0], wr_dat[0]);
            end
        end
        checks = checks + 1;
        if (ack_cnt - a0 != 1 || last_ack_cyc - last_vack_cyc < 1 || last_ack_cyc - last_vack_cyc > 2) begin
            failures = failures + 1;
            $display("[TB] FAIL putchar_ack acks=%0d gap=%0d required 1 ack, gap 1..2",
                     ack_cnt - a0, last_ack_cyc - last_vack_cyc);
        end
        checks = checks + 1;
        if (DAT_O !== {19'd0, 6'd0, 7'd1} || cursor_addr !== 13'd1) begin
            failures = failures + 1;
            $display("[TB] FAIL putchar_cursor DAT_O=%h cursor_addr=%0d required 00000001/1", DAT_O, cursor_addr);
        end
        cpu_cmd(2'd3, 1'b0, 32'd0, 20, lat, ok, rd);
        checks = checks + 1;
        if (!ok || lat != 1 || rd[12:0] !== 13'd1) begin
            failures = failures + 1;
            $display("[TB] FAIL status_read ok=%b lat=%0d pos=%h required 1/1/0001", ok, lat, rd[12:0]);
        end
    endtask

    task automatic test_wrap();
        int lat; logic ok; logic [31:0] rd;
        cpu_cmd(2'd1, 1'b1, 32'h0000_024F, 20, lat, ok, rd);
        checks = checks + 1;
        if (!ok || lat != 1 || DAT_O !== {19'd0, 6'd2, 7'd79}) begin
            failures = failures + 1;
            $display("[TB] FAIL set_cursor ok=%b lat=%0d DAT_O=%h required 1/1/%h", ok, lat, DAT_O, {19'd0, 6'd2, 7'd79});
        end
        wr_addr.delete(); wr_dat.delete();
        cpu_cmd(2'd0, 1'b1, 32'h0000_075A, 100, lat, ok, rd);
        checks = checks + 1;
        if (!ok || wr_addr.size() != 1 || wr_addr[0] !== 32'd239 || wr_dat[0] !== 32'h0000_075A) begin
            failures = failures + 1;
            $display("[TB] FAIL wrap_write ok=%b writes=%0d addr=%0d required 1/1/239", ok, wr_addr.size(),
                     (wr_addr.size() > 0) ? wr_addr[0] : 32'hFFFF_FFFF);
        end
        checks = checks + 1;
        if (DAT_O !== {19'd0, 6'd3, 7'd0}) begin
            failures = failures + 1;
            $display("[TB] FAIL wrap_cursor DAT_O=%h required %h", DAT_O, {19'd0, 6'd3, 7'd0});
        end
    endtask

    task automatic test_clamp();
        int lat; logic ok; logic [31:0] rd;
        cpu_cmd(2'd1, 1'b1, 32'h0000_3F64, 20, lat, ok, rd);
        checks = checks + 1;
        if (!ok || DAT_O !== {19'd0, 6'd59, 7'd79}) begin
            failures = failures + 1;
            $display("[TB] FAIL clamp ok=%b DAT_O=%h required %h", ok, DAT_O, {19'd0, 6'd59, 7'd79});
        end
    endtask

    task automatic test_scroll();
        int lat; logic ok; logic [31:0] rd; int a0; int bad;
        ack_delay = 1;
        cpu_cmd(2'd1, 1'b1, 32'h0000_3B00, 20, lat, ok, rd);
        wr_addr.delete(); wr_dat.delete();
        a0 = ack_cnt;
        cpu_cmd(2'd0, 1'b1, 32'h0000_000A, 1000, lat, ok, rd);
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] !== 32'(i) || wr_dat[i] !== 32'h0000_0020) bad++;
        checks = checks + 1;
        if (!ok || wr_addr.size() != 80 || bad != 0) begin
            failures = failures + 1;
            $display("[TB] FAIL scroll_lf_writes ok=%b writes=%0d bad=%0d required 1/80/0", ok, wr_addr.size(), bad);
        end
        checks = checks + 1;
        if (row_offset !== 6'd1 || DAT_O !== {19'd0, 6'd59, 7'd0}) begin
            failures = failures + 1;
            $display("[TB] FAIL scroll_lf_state row_offset=%0d DAT_O=%h required 1/%h", row_offset, DAT_O, {19'd0, 6'd59, 7'd0});
        end
        checks = checks + 1;
        if (ack_cnt - a0 != 1 || last_ack_cyc - last_vack_cyc < 1 || last_ack_cyc - last_vack_cyc > 2) begin
            failures = failures + 1;
            $display("[TB] FAIL scroll_lf_ack acks=%0d gap=%0d required 1 ack, gap 1..2", ack_cnt - a0, last_ack_cyc - last_vack_cyc);
        end
        cpu_cmd(2'd1, 1'b1, 32'h0000_3B4F, 20, lat, ok, rd);
        wr_addr.delete(); wr_dat.delete();
        cpu_cmd(2'd0, 1'b1, 32'h0000_0751, 1000, lat, ok, rd);
        bad = 0;
        for (int i = 1; i < wr_addr.size(); i++)
            if (wr_addr[i] !== 32'(79 + i) || wr_dat[i] !== 32'h0000_0020) bad++;
        checks = checks + 1;
        if (!ok || wr_addr.size() != 81 || wr_addr[0] !== 32'd79 || wr_dat[0] !== 32'h0000_0751 || bad != 0) begin
            failures = failures + 1;
            $display("[TB] FAIL scroll_wrap_writes ok=%b writes=%0d bad=%0d required 1/81/0", ok, wr_addr.size(), bad);
        end
        checks = checks + 1;
        if (row_offset !== 6'd2 || DAT_O !== {19'd0, 6'd59, 7'd0}) begin
            failures = failures + 1;
            $display("[TB] FAIL scroll_wrap_state row_offset=%0d DAT_O=%h required 2/%h", row_offset, DAT_O, {19'd0, 6'd59, 7'd0});
        end
    endtask

    task automatic test_cr_lf();
        int lat; logic ok; logic [31:0] rd;
        cpu_cmd(2'd1, 1'b1, 32'h0000_050A, 20, lat, ok, rd);
        wr_addr.delete(); wr_dat.delete();
        cpu_cmd(2'd0, 1'b1, 32'h0000_000D, 20, lat, ok, rd);
        checks = checks + 1;
        if (!ok || lat > 3 || wr_addr.size() != 0 || DAT_O !== {19'd0, 6'd5, 7'd0}) begin
            failures = failures + 1;
            $display("[TB] FAIL cr ok=%b lat=%0d writes=%0d DAT_O=%h required 1/<=3/0/%h", ok, lat, wr_addr.size(), DAT_O, {19'd0, 6'd5, 7'd0});
        end
        cpu_cmd(2'd0, 1'b1, 32'h0000_000A, 20, lat, ok, rd);
        checks = checks + 1;
        if (!ok || lat > 3 || wr_addr.size() != 0 || DAT_O !== {19'd0, 6'd6, 7'd0} || row_offset !== 6'd2) begin
            failures = failures + 1;
            $display("[TB] FAIL lf ok=%b lat=%0d writes=%0d DAT_O=%h row_offset=%0d required 1/<=3/0/%h/2",
                     ok, lat, wr_addr.size(), DAT_O, row_offset, {19'd0, 6'd6, 7'd0});
        end
    endtask

    task automatic test_backspace();
        int lat; logic ok; logic [31:0] rd; int a0;
        cpu_cmd(2'd1, 1'b1, 32'h0000_0400, 20, lat, ok, rd);
        wr_addr.delete(); wr_dat.delete();
        a0 = ack_cnt;
        cpu_cmd(2'd0, 1'b1, 32'h0000_0008, 20, lat, ok, rd);
        checks = checks + 1;
        if (!ok || ack_cnt - a0 != 1 || wr_addr.size() != 0 || DAT_O !== {19'd0, 6'd4, 7'd0}) begin
            failures = failures + 1;
            $display("[TB] FAIL bs_col0 ok=%b acks=%0d writes=%0d DAT_O=%h required 1/1/0/%h", ok, ack_cnt - a0, wr_addr.size(), DAT_O, {19'd0, 6'd4, 7'd0});
        end
        cpu_cmd(2'd1, 1'b1, 32'h0000_0403, 20, lat, ok, rd);
        wr_addr.delete(); wr_dat.delete();
        cpu_cmd(2'd0, 1'b1, 32'h0000_0008, 100, lat, ok, rd);
        checks = checks + 1;
        if (!ok || wr_addr.size() != 1 || wr_addr[0] !== 32'd482 || wr_dat[0] !== 32'h0000_0020) begin
            failures = failures + 1;
            $display("[TB] FAIL bs_col3_write ok=%b writes=%0d addr=%0d required 1/1/482", ok, wr_addr.size(),
                     (wr_addr.size() > 0) ? wr_addr[0] : 32'hFFFF_FFFF);
        end
        checks = checks + 1;
        if (DAT_O !== {19'd0, 6'd4, 7'd2}) begin
            failures = failures + 1;
            $display("[TB] FAIL bs_col3_cursor DAT_O=%h required %h", DAT_O, {19'd0, 6'd4, 7'd2});
        end
    endtask

    task automatic test_clear();
        int lat; logic ok; logic [31:0] rd; int bad;
        ack_delay = 1;
        cpu_cmd(2'd1, 1'b1, 32'h0000_3B00, 20, lat, ok, rd);
        repeat (3) cpu_cmd(2'd0, 1'b1, 32'h0000_000A, 1000, lat, ok, rd);
        checks = checks + 1;
        if (row_offset !== 6'd5) begin
            failures = failures + 1;
            $display("[TB] FAIL clear_setup row_offset=%0d required 5", row_offset);
        end
        ack_delay = 0;
        wr_addr.delete(); wr_dat.delete();
        cpu_cmd(2'd2, 1'b1, 32'd0, 20000, lat, ok, rd);
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] !== 32'(i) || wr_dat[i] !== 32'h0000_0020) bad++;
        checks = checks + 1;
        if (!ok || wr_addr.size() != 4800 || bad != 0) begin
            failures = failures + 1;
            $display("[TB] FAIL clear_writes ok=%b writes=%0d bad=%0d required 1/4800/0", ok, wr_addr.size(), bad);
        end
        checks = checks + 1;
        if (row_offset !== 6'd0 || DAT_O !== 32'd0 || cursor_addr !== 13'd0) begin
            failures = failures + 1;
            $display("[TB] FAIL clear_state row_offset=%0d DAT_O=%h cursor_addr=%0d required 0/0/0", row_offset, DAT_O, cursor_addr);
        end
    endtask

    task automatic test_reset_mid_clear();
        int lat; logic ok; logic [31:0] rd; int a0; logic found;
        ack_delay = 1;
        cpu_cmd(2'd1, 1'b1, 32'h0000_3B00, 20, lat, ok, rd);
        cpu_cmd(2'd0, 1'b1, 32'h0000_000A, 1000, lat, ok, rd);
        cpu_cmd(2'd1, 1'b1, 32'h0000_0A05, 20, lat, ok, rd);
        STB = 1'b1; WE = 1'b1; ADDR = 2'd2; DAT_I = 32'd0;
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (V_STB && V_ADDR == 32'd100) begin
                found = 1'b1;
                break;
            end
        end
        checks = checks + 1;
        if (!found) begin
            failures = failures + 1;
            $display("[TB] FAIL midclear_reach found=%b required 1", found);
        end
        reset = 1'b1;
        STB   = 1'b0;
        a0    = ack_cnt;
        tick(1);
        checks = checks + 1;
        if (V_STB !== 1'b0 || ACK !== 1'b0 || row_offset !== 6'd0) begin
            failures = failures + 1;
            $display("[TB] FAIL midclear_abort V_STB=%b ACK=%b row_offset=%0d required 0/0/0", V_STB, ACK, row_offset);
        end
        tick(1);
        reset = 1'b0;
        tick(4);
        checks = checks + 1;
        if (ack_cnt != a0 || DAT_O !== 32'd0) begin
            failures = failures + 1;
            $display("[TB] FAIL midclear_quiet acks=%0d DAT_O=%h required 0/0", ack_cnt - a0, DAT_O);
        end
        wr_addr.delete(); wr_dat.delete();
        cpu_cmd(2'd0, 1'b1, 32'h0000_0741, 100, lat, ok, rd);
        checks = checks + 1;
        if (!ok || wr_addr.size() != 1 || wr_addr[0] !== 32'd0 || wr_dat[0] !== 32'h0000_0741) begin
            failures = failures + 1;
            $display("[TB] FAIL midclear_putchar ok=%b writes=%0d addr=%0d required 1/1/0", ok, wr_addr.size(),
                     (wr_addr.size() > 0) ? wr_addr[0] : 32'hFFFF_FFFF);
        end
        checks = checks + 1;
        if (proto_err != 0) begin
            failures = failures + 1;
            $display("[TB] FAIL vbus_protocol violations=%0d required 0", proto_err);
        end
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; STB = 1'b0; WE = 1'b0; ADDR = 2'd0; DAT_I = 32'd0;
        v_ack = 1'b0; ack_delay = 1; wait_cnt = 0; cyc = 0; ack_cnt = 0;
        last_ack_cyc = 0; last_vack_cyc = 0; proto_err = 0; hold = 1'b0;
        hold_addr = 32'd0; hold_dat = 32'd0;
        checks = 0; failures = 0;
        test_reset();
        test_putchar();
        test_wrap();
        test_clamp();
        test_scroll();
        test_cr_lf();
        test_backspace();
        test_clear();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/text_console_ctrl.md
Name: text_console_ctrl

Overview:
- Command-level sequencer in front of the text-mode video card; the CPU issues putchar/cursor/clear commands on the slave bus instead of raw cell writes.
- Tracks the cursor and drives the card's write bus (STB/ACK) one cell at a time.
- Scrolls by programming a row_offset into the card and blanking the new bottom row, so no VRAM read-back is needed.

Parameters:
COLS, 80, characters per row
ROWS, 60, rows per screen
FILL, 16'h0020, cell value written by clear/scroll/backspace
BLINK_DIV, 25000000, clk cycles per cursor blink half-period (CURSOR_EN only)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
STB  in  1  CPU strobe; held by master until ACK
WE  in  1  1 = command write, 0 = status read
ADDR  in  2  command select: 0 putchar, 1 set cursor, 2 clear screen, 3 status
DAT_I  in  32  command data
DAT_O  out  32  status {18'b0, busy, row[5:0], col[6:0]}
ACK  out  1  one-cycle completion pulse to CPU
V_STB  out  1  write strobe to video card
V_ADDR  out  32  cell address to video card
V_DAT  out  32  cell data {16'b0, attr, char}
V_ACK  in  1  video card write acknowledge
row_offset  out  6  physical row shown at logical row 0 (card adds modulo ROWS)
cursor_vis  out  1  cursor overlay enable (CURSOR_EN)
cursor_addr  out  13  physical cell address of cursor

Behaviour:
- Reset values: ACK 0, V_STB 0, V_ADDR 0, V_DAT 0, row_offset 0, col 0, row 0, state IDLE, cursor_vis 0. Reset mid-operation aborts instantly; no clear, no pending ACK.
- Physical address = ((row + row_offset) mod ROWS) * COLS + col; 13-bit arithmetic, zero-extended onto V_ADDR.
- CPU accept: in IDLE, STB=1 and ACK=0 latches ADDR/WE/DAT_I. STB in any other state is ignored (not queued). Master must drop STB the cycle after ACK.
- Status read (WE=0): ACK the next cycle, no state change. DAT_O is combinational and always valid.
- Video bus: V_STB/V_ADDR/V_DAT held stable until V_ACK=1. V_STB is low the cycle after each V_ACK, so one write completes per 2-3 cycles.
- States: IDLE, PUT_WR, ADVANCE, SCROLL_CLR, CLEAR, DONE. DONE pulses ACK for 1 cycle, then returns to IDLE.
- putchar (ADDR 0): DAT_I[7:0] = char, DAT_I[15:8] = attr.
  - 0x0A: col=0, row+1, no write.
  - 0x0D: col=0, no write.
  - 0x08: if col>0, col-1 and write FILL there; at col 0, no-op.
  - Otherwise: PUT_WR writes {attr,char} at cursor, then ADVANCE does col+1; col==COLS wraps to col 0, row+1.
- Row overflow: row==ROWS-1 with increment means row stays ROWS-1, row_offset = (row_offset+1) mod ROWS, then SCROLL_CLR writes FILL to the COLS cells of the new bottom physical row (old row_offset), then DONE.
- set cursor (ADDR 1): col=DAT_I[6:0], row=DAT_I[13:8]. Out-of-range values are clamped to COLS-1 / ROWS-1. ACK after 1 cycle.
- clear (ADDR 2): writes FILL to physical addresses 0..COLS*ROWS-1 in order, then sets row_offset 0, col 0, row 0, then ACK.
- busy = (state != IDLE).
- ACK latency:
  - putchar without scroll: ACK 1 cycle after final V_ACK.
  - newline/CR without scroll: ACK within 3 cycles of accept.

Optional Feature:
- CURSOR_EN defined:
  - BLINK_DIV counter toggles a phase bit.
  - cursor_vis = phase & ~busy.
  - cursor_addr tracks the physical cursor address every cycle.
  - Counter and phase reset to 0.
- Undefined: no counter; cursor_vis tied 0; cursor_addr still driven.

Test Plan:
- Reset, putchar 0x41 attr 0x07 (card acks 1 cycle after V_STB) -> one V_STB with V_ADDR 0, V_DAT 0x0741; ACK once; status reads col 1 row 0.
- Set cursor col 79 row 2, putchar 'Z' -> write at V_ADDR 239; status col 0 row 3.
- Set cursor col 0 row 59, putchar 0x0A -> row_offset 1; exactly 80 writes of 0x0020 to addresses 0..79; row stays 59; single ACK after the 80th V_ACK.
- Clear screen with row_offset 5 -> 4800 writes covering addresses 0..4799 once each; afterwards row_offset 0, cursor 0/0, busy 0.
- Backspace at col 0, then at col 3 -> first: no V_STB, ACK; second: FILL written at col 2, status col 2.
- Issue reset while CLEAR is at address 100 -> V_STB 0 next cycle; no ACK; row_offset 0; a new putchar then writes address 0.
